mm_ss_counter: RTL

BCD minutes:seconds counter, 00:00 to 59:59. It consumes the single-cycle carry pulse produced by an upstream mod-N prescaler stage, and advances by one second on each pulse while running. The block provides:
- start/stop control;
- a valid/ready load port for presetting the time;
- a registered hour-carry pulse for the next cascaded stage.

---
 rtl/mm_ss_pkg.sv | 28 ++
 rtl/mm_ss_counter_bcd_digit.sv | 28 ++
 rtl/mm_ss_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/mm_ss_pkg.sv
// Shared constants, state encoding and digit helpers for the mm:ss counter.
package mm_ss_pkg;

  localparam int DIGIT_W      = 4;
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;
  localparam logic [15:0] MAX_TIME = 16'h5959;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d, input int mod);
    return int'(d) < mod;
  endfunction

  // Value a digit register will hold after the coming edge (no load in flight).
  function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] q,
                                                    input logic inc, input logic wrap);
    if (wrap)     return '0;
    else if (inc) return q + 1'b1;
    else          return q;
  endfunction

endpackage

// File: rtl/mm_ss_counter_bcd_digit.sv
// One mod-MOD BCD digit with synchronous preset; wrap flags the carry to the next digit.
module bcd_digit
  import mm_ss_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MOD - 1);

  assign wrap = inc && (q == LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= load_val;
    else if (wrap) q <= '0;
    else if (inc)  q <= q + 1'b1;
  end

endmodule

// File: rtl/mm_ss_counter.sv
// BCD mm:ss counter with start/stop, preset load port and hour-carry pulse.
// Define MM_SS_ALARM_EN to add the alarm_data input and alarm pulse output.
module mm_ss_counter
  import mm_ss_pkg::*;
#(
  parameter int ONES_MOD = 10,
  parameter int TENS_MOD = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         load_valid,
  input  logic [15:0]  load_data,
  output logic         load_ready,
  output logic         load_err,
  output logic [3:0]   sec_ones,
  output logic [3:0]   sec_tens,
  output logic [3:0]   min_ones,
  output logic [3:0]   min_tens,
  output logic         running,
  output logic         carry_out
`ifdef MM_SS_ALARM_EN
  ,
  input  logic [15:0]  alarm_data,
  output logic         alarm
`endif
);

  state_t state;

  logic [DIGIT_W-1:0] ld_so, ld_st, ld_mo, ld_mt;
  logic load_ok, accept, do_load, count_en;
  logic w_so, w_st, w_mo, w_mt;

  assign ld_so = load_data[SEC_ONES_LSB +: DIGIT_W];
  assign ld_st = load_data[SEC_TENS_LSB +: DIGIT_W];
  assign ld_mo = load_data[MIN_ONES_LSB +: DIGIT_W];
  assign ld_mt = load_data[MIN_TENS_LSB +: DIGIT_W];

  assign load_ok = digit_ok(ld_so, ONES_MOD) && digit_ok(ld_st, TENS_MOD) &&
                   digit_ok(ld_mo, ONES_MOD) && digit_ok(ld_mt, TENS_MOD);

  assign load_ready = (state == STOP);
  assign accept     = load_valid && load_ready;
  assign do_load    = accept && load_ok;
  assign count_en   = tick && (state == RUN);
  assign running    = (state == RUN);

  // Each wrap already includes its own inc, so it is the full carry into the next digit.
  bcd_digit #(.MOD(ONES_MOD)) u_sec_ones (
    .clk(clk), .rst(rst), .inc(count_en), .load(do_load), .load_val(ld_so),
    .q(sec_ones), .wrap(w_so));
  bcd_digit #(.MOD(TENS_MOD)) u_sec_tens (
    .clk(clk), .rst(rst), .inc(w_so), .load(do_load), .load_val(ld_st),
    .q(sec_tens), .wrap(w_st));
  bcd_digit #(.MOD(ONES_MOD)) u_min_ones (
    .clk(clk), .rst(rst), .inc(w_st), .load(do_load), .load_val(ld_mo),
    .q(min_ones), .wrap(w_mo));
  bcd_digit #(.MOD(TENS_MOD)) u_min_tens (
    .clk(clk), .rst(rst), .inc(w_mo), .load(do_load), .load_val(ld_mt),
    .q(min_tens), .wrap(w_mt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STOP;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      carry_out <= w_mt;
      load_err  <= accept && !load_ok;
      if (stop)       state <= STOP;
      else if (start) state <= RUN;
    end
  end

`ifdef MM_SS_ALARM_EN
  logic [15:0] nxt_time;

  assign nxt_time = {next_digit(min_tens, w_mo, w_mt), next_digit(min_ones, w_st, w_mo),
                     next_digit(sec_tens, w_so, w_st), next_digit(sec_ones, count_en, w_so)};

  // Only a counted tick can raise the alarm; loads happen in STOP where count_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm <= 1'b0;
    else     alarm <= count_en && (nxt_time == alarm_data);
  end
`endif

endmodule
